// File: rtl/bcd_digit_packer.sv
// Collects tens-first BCD digits off a val/rdy stream into a packed
// two-digit word, flagging any non-decimal nibble for the consumer.
module bcd_digit_packer (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_val,
   output logic       in_rdy,
   input  logic [3:0] in_digit,
   input  logic       in_last,
   output logic       out_val,
   input  logic       out_rdy,
   output logic [7:0] out,
   output logic       out_err
);

   typedef enum logic [1:0] {
      TENS = 2'd0,
      ONES = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] tens_q, tens_d;
   logic       err_acc_q, err_acc_d;
   logic [7:0] out_q, out_d;
   logic       out_err_q, out_err_d;

   logic in_fire;
   logic out_fire;
   logic digit_bad;

   // Ready depends on state only, so upstream never sees a path from out_rdy.
   assign in_rdy    = ~reset & (state_q != FULL);
   assign out_val   = (state_q == FULL);
   assign out       = out_q;
   assign out_err   = out_err_q;
   assign in_fire   = in_val & in_rdy;
   assign out_fire  = out_val & out_rdy;
   assign digit_bad = (in_digit > 4'd9);

   always_comb begin
      state_d   = state_q;
      tens_d    = tens_q;
      err_acc_d = err_acc_q;
      out_d     = out_q;
      out_err_d = out_err_q;
      unique case (state_q)
         TENS: begin
            if (in_fire) begin
               if (in_last) begin
                  out_d     = {4'h0, in_digit};
                  out_err_d = digit_bad;
                  state_d   = FULL;
               end else begin
                  tens_d    = in_digit;
                  err_acc_d = digit_bad;
                  state_d   = ONES;
               end
            end
         end
         ONES: begin
            // Second digit always closes the word; in_last is irrelevant here.
            if (in_fire) begin
               out_d     = {tens_q, in_digit};
               out_err_d = err_acc_q | digit_bad;
               state_d   = FULL;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_d = TENS;
            end
         end
         default: state_d = TENS;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= TENS;
         tens_q    <= 4'h0;
         err_acc_q <= 1'b0;
         out_q     <= 8'h00;
         out_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tens_q    <= tens_d;
         err_acc_q <= err_acc_d;
         out_q     <= out_d;
         out_err_q <= out_err_d;
      end
   end

endmodule

// File: tb/tb_bcd_digit_packer.sv
// Directed vector bench for bcd_digit_packer: table of per-cycle
// stimulus/expectations plus hand sequences for asynchronous reset.
module tb_bcd_digit_packer;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_val;
   logic       in_rdy;
   logic [3:0] in_digit;
   logic       in_last;
   logic       out_val;
   logic       out_rdy;
   logic [7:0] out;
   logic       out_err;

   int checks = 0;
   int errors = 0;

   bcd_digit_packer dut (
      .clk      (clk),
      .reset    (reset),
      .in_val   (in_val),
      .in_rdy   (in_rdy),
      .in_digit (in_digit),
      .in_last  (in_last),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out      (out),
      .out_err  (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       l;
      logic       ordy;
      logic       e_rdy;
      logic       e_val;
      logic [7:0] e_out;
      logic       e_err;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic v, logic [3:0] d, logic l, logic ordy,
                               logic e_rdy, logic e_val, logic [7:0] e_out,
                               logic e_err);
      vec_t r;
      r.v = v; r.d = d; r.l = l; r.ordy = ordy;
      r.e_rdy = e_rdy; r.e_val = e_val; r.e_out = e_out; r.e_err = e_err;
      return r;
   endfunction

   task automatic chk(string name, int idx, logic [7:0] got, logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
      end
   endtask

   task automatic chk_all(int idx, logic e_rdy, logic e_val,
                          logic [7:0] e_out, logic e_err);
      chk("in_rdy", idx, {7'd0, in_rdy}, {7'd0, e_rdy});
      chk("out_val", idx, {7'd0, out_val}, {7'd0, e_val});
      chk("out", idx, out, e_out);
      chk("out_err", idx, {7'd0, out_err}, {7'd0, e_err});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // two-digit 1,5
      tv.push_back(mk(1, 4'h1, 0, 1, 1, 0, 8'h00, 0));
      tv.push_back(mk(1, 4'h5, 1, 1, 1, 0, 8'h00, 0));
      tv.push_back(mk(0, 4'h0, 0, 1, 0, 1, 8'h15, 0));
      // single digit 7, then 9,9
      tv.push_back(mk(1, 4'h7, 1, 1, 1, 0, 8'h15, 0));
      tv.push_back(mk(0, 4'h0, 0, 1, 0, 1, 8'h07, 0));
      tv.push_back(mk(1, 4'h9, 0, 1, 1, 0, 8'h07, 0));
      tv.push_back(mk(1, 4'h9, 1, 1, 1, 0, 8'h07, 0));
      tv.push_back(mk(0, 4'h0, 0, 1, 0, 1, 8'h99, 0));
      // 4,C with in_last=0 on second digit (ignored in ONES)
      tv.push_back(mk(1, 4'h4, 0, 1, 1, 0, 8'h99, 0));
      tv.push_back(mk(1, 4'hC, 0, 1, 1, 0, 8'h99, 0));
      tv.push_back(mk(0, 4'h0, 0, 1, 0, 1, 8'h4C, 1));
      // single B
      tv.push_back(mk(1, 4'hB, 1, 1, 1, 0, 8'h4C, 1));
      tv.push_back(mk(0, 4'h0, 0, 1, 0, 1, 8'h0B, 1));
      // 2,3 clears error
      tv.push_back(mk(1, 4'h2, 0, 1, 1, 0, 8'h0B, 1));
      tv.push_back(mk(1, 4'h3, 1, 1, 1, 0, 8'h0B, 1));
      tv.push_back(mk(0, 4'h0, 0, 1, 0, 1, 8'h23, 0));
      // backpressure 3,8 with digit 6 waiting
      tv.push_back(mk(1, 4'h3, 0, 0, 1, 0, 8'h23, 0));
      tv.push_back(mk(1, 4'h8, 1, 0, 1, 0, 8'h23, 0));
      for (int i = 0; i < 5; i++)
         tv.push_back(mk(1, 4'h6, 0, 0, 0, 1, 8'h38, 0));
      tv.push_back(mk(1, 4'h6, 0, 1, 0, 1, 8'h38, 0));
      tv.push_back(mk(1, 4'h6, 0, 1, 1, 0, 8'h38, 0));
      tv.push_back(mk(1, 4'h0, 1, 1, 1, 0, 8'h38, 0));
      tv.push_back(mk(0, 4'h0, 0, 1, 0, 1, 8'h60, 0));
      tv.push_back(mk(0, 4'h0, 0, 1, 1, 0, 8'h60, 0));
      // bubbles: 0, four idles, 9
      tv.push_back(mk(1, 4'h0, 0, 1, 1, 0, 8'h60, 0));
      for (int i = 0; i < 4; i++)
         tv.push_back(mk(0, 4'h0, 0, 1, 1, 0, 8'h60, 0));
      tv.push_back(mk(1, 4'h9, 1, 1, 1, 0, 8'h60, 0));
      tv.push_back(mk(0, 4'h0, 0, 1, 0, 1, 8'h09, 0));
      tv.push_back(mk(0, 4'h0, 0, 1, 1, 0, 8'h09, 0));
      tv.push_back(mk(0, 4'h0, 0, 1, 1, 0, 8'h09, 0));

      reset    = 1'b1;
      in_val   = 1'b0;
      in_digit = 4'h0;
      in_last  = 1'b0;
      out_rdy  = 1'b1;
      #2;
      chk_all(-1, 0, 0, 8'h00, 0);
      step();
      reset = 1'b0;
      #1;

      foreach (tv[i]) begin
         in_val   = tv[i].v;
         in_digit = tv[i].d;
         in_last  = tv[i].l;
         out_rdy  = tv[i].ordy;
         #0;
         chk_all(i, tv[i].e_rdy, tv[i].e_val, tv[i].e_out, tv[i].e_err);
         step();
      end

      // reset while holding a tens digit
      in_val   = 1'b1;
      in_digit = 4'h5;
      in_last  = 1'b0;
      step();
      in_val = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk_all(100, 0, 0, 8'h00, 0);
      #1;
      reset = 1'b0;
      #1;
      chk_all(101, 1, 0, 8'h00, 0);
      in_val   = 1'b1;
      in_digit = 4'h2;
      in_last  = 1'b0;
      out_rdy  = 1'b0;
      step();
      in_digit = 4'h1;
      in_last  = 1'b1;
      step();
      in_val = 1'b0;
      chk_all(102, 0, 1, 8'h21, 0);
      step();
      chk_all(103, 0, 1, 8'h21, 0);

      // reset while a word is pending: it must not be emitted
      #2;
      reset = 1'b1;
      #1;
      chk_all(104, 0, 0, 8'h00, 0);
      #1;
      reset   = 1'b0;
      out_rdy = 1'b1;
      step();
      chk_all(105, 1, 0, 8'h00, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_digit_packer.md
Name: bcd_digit_packer

Overview:
- Sequential front-end stage that collects serially entered BCD digits (keypad/UART style, tens digit first) over a val/rdy stream.
- Assembles them into the 8-bit packed two-digit BCD word consumed directly by the downstream BCD-to-binary converter.
- Flags any non-decimal nibble so downstream logic can qualify the converted value.

Parameters:
None.

Ports:
- clk        input   1  clock; all state updates on rising edge
- reset      input   1  asynchronous, active-high reset
- in_val     input   1  input digit valid
- in_rdy     output  1  block can accept a digit this cycle
- in_digit   input   4  BCD digit (values 10-15 accepted but flagged)
- in_last    input   1  this digit is the final digit of the number
- out_val    output  1  packed word valid
- out_rdy    input   1  downstream accepts packed word
- out        output  8  packed BCD: [7:4] tens, [3:0] ones
- out_err    output  1  at least one digit of the word was > 9

Behaviour:
- Input transfer (in fire) = in_val & in_rdy at a rising edge; output transfer (out fire) = out_val & out_rdy at a rising edge.
- States: TENS (awaiting first digit), ONES (awaiting second digit), FULL (word held for output).
- Reset (asynchronous, active-high):
  - state = TENS.
  - out = 8'h00, out_err = 0, out_val = 0.
  - Internal tens register and error accumulator cleared.
  - in_rdy forced 0 while reset is asserted.
- in_rdy = 1 in TENS and ONES, 0 in FULL. Combinational from state only, with no dependence on out_rdy.
- out_val = 1 exactly when state == FULL. Registered, with no combinational path from in_val.
- TENS, in fire with in_last = 1 (single-digit number):
  - out <= {4'h0, in_digit}; out_err <= (in_digit > 9).
  - Go to FULL.
- TENS, in fire with in_last = 0:
  - tens_reg <= in_digit; err_acc <= (in_digit > 9).
  - Go to ONES.
- ONES, in fire:
  - out <= {tens_reg, in_digit}; out_err <= err_acc | (in_digit > 9).
  - Go to FULL.
  - in_last is ignored; a number is never more than two digits.
- FULL:
  - out and out_err held stable while out_val = 1 and out_rdy = 0.
  - On out fire, go to TENS; out_val is 0 the following cycle.
- After a transfer, out and out_err keep their last values; only out_val drops. The downstream stage must qualify with out_val.
- No in fire in any state: all registers unchanged.
- Latency: out_val rises the cycle after the digit that completes the word is accepted.
- Throughput: one 2-digit word per 3 cycles, or one 1-digit word per 2 cycles, with out_rdy held high. No same-cycle input/output overlap in FULL.
- Digits 10-15 are stored unmodified in their nibble position and never clamped; only out_err marks them.
- Reset asserted mid-word (state ONES or FULL):
  - Partial or pending word discarded and not emitted.
  - Block returns to TENS with all outputs at reset values.
  - First digit after reset deassertion is treated as a tens digit.
- out_rdy held high while out_val = 0 has no effect.

Test Plan:
- Reset, then digits 1 (in_last=0), 5 (in_last=1) back-to-back with out_rdy=1 -> out_val high the cycle after the second digit; out=8'h15, out_err=0; in_rdy=0 that cycle and 1 the next.
- Single digit 7 with in_last=1 -> out=8'h07, out_err=0. Then digit 9 with in_last=0, then 9 -> out=8'h99.
- Digit 4 then digit 12 (4'hC) -> out=8'h4C, out_err=1. Digit 11 with in_last=1 -> out=8'h0B, out_err=1. Next word 2,3 -> out_err=0, confirming the error flag clears per word.
- Backpressure: word 3,8 with out_rdy=0 for 5 cycles:
  - out=8'h38 held stable and out_val stays 1.
  - in_rdy=0, and an in_val=1 digit 6 presented meanwhile is not consumed.
  - out_rdy=1 -> transfer; digit 6 then accepted as the tens digit.
- Reset mid-word: accept digit 5, assert reset asynchronously between edges -> outputs 0 and in_rdy 0 immediately. Deassert, send 2,1 -> out=8'h21 (the 5 is discarded).
- Bubbles: digits 0 then 9 separated by 4 idle cycles (in_val=0) -> out=8'h09 once, with no spurious out_val during the gaps.
